// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC operand buffer and its neighbours.
package mac_pkg;

    // Default operand width and buffer pointer width.
    localparam int DATA_W = 8;
    localparam int BUF_W  = 2;

    // One stored operand pair together with its accumulation-group tag.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } operand_entry_t;

endpackage

// File: rtl/mac_operand_buffer_ptr_ctr_clr.sv
// Wrap-around pointer counter with enable and a synchronous clear.
// The clear has priority over the enable, so a flush always returns the pointer to 0.
module ptr_ctr_clr #(
    parameter int BufferWidth = 2
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   EN,
    output logic [BufferWidth-1:0] Pointer
);

    localparam logic [BufferWidth-1:0] PtrZero = BufferWidth'(0);
    localparam logic [BufferWidth-1:0] PtrOne  = BufferWidth'(1);

    logic [BufferWidth-1:0] ptr_d;
    logic [BufferWidth-1:0] ptr_q;

    // Next pointer: clear, advance with natural wrap, or hold.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = PtrZero;
        end else if (EN) begin
            ptr_d = ptr_q + PtrOne;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PtrZero;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign Pointer = ptr_q;

endmodule

// File: rtl/mac_operand_buffer.sv
// Circular operand buffer feeding the MAC datapath.
// Pairs are accepted over valid/ready, stored in a small register array and
// presented first-word-fall-through: the oldest entry is always on out_*.
// Occupancy is tracked in a registered count; full/empty are decoded from it.
module mac_operand_buffer
    import mac_pkg::*;
#(
    parameter int BufferWidth = BUF_W,
    parameter int DataWidth   = DATA_W
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataWidth-1:0] in_a,
    input  logic [DataWidth-1:0] in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] out_a,
    output logic [DataWidth-1:0] out_b,
    output logic                 out_last,
    output logic [BufferWidth:0] count,
    output logic                 full,
    output logic                 empty
);

    localparam int Depth = 2 ** BufferWidth;
    localparam logic [BufferWidth:0] CountMax  = (BufferWidth + 1)'(Depth);
    localparam logic [BufferWidth:0] CountOne  = (BufferWidth + 1)'(1);
    localparam logic [BufferWidth:0] CountZero = (BufferWidth + 1)'(0);

    // Storage word sized by the instance's DataWidth.
    typedef struct packed {
        logic                 last;
        logic [DataWidth-1:0] a;
        logic [DataWidth-1:0] b;
    } entry_t;

    entry_t                 mem_q [Depth];
    entry_t                 mem_d [Depth];
    logic [BufferWidth:0]   count_q;
    logic [BufferWidth:0]   count_d;
    logic [BufferWidth-1:0] wr_ptr_s;
    logic [BufferWidth-1:0] rd_ptr_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   full_s;
    logic                   empty_s;
    entry_t                 entry_in_s;
    entry_t                 entry_out_s;

    assign full_s  = (count_q == CountMax);
    assign empty_s = (count_q == CountZero);

    // A flush cycle neither accepts nor consumes anything.
    assign push_s = in_valid & ~full_s & ~flush;
    assign pop_s  = out_ready & ~empty_s & ~flush;

    assign entry_in_s  = '{last: in_last, a: in_a, b: in_b};
    assign entry_out_s = mem_q[rd_ptr_s];

    // Write pointer advances on every accepted pair.
    ptr_ctr_clr #(.BufferWidth(BufferWidth)) u_wr_ptr (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .EN      (push_s),
        .Pointer (wr_ptr_s)
    );

    // Read pointer advances on every consumed pair.
    ptr_ctr_clr #(.BufferWidth(BufferWidth)) u_rd_ptr (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .EN      (pop_s),
        .Pointer (rd_ptr_s)
    );

    // Next occupancy: flush clears, push-only increments, pop-only decrements.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = CountZero;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CountOne;
                2'b01:   count_d = count_q - CountOne;
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= CountZero;
        end else begin
            count_q <= count_d;
        end
    end

    // Next storage contents: only the slot under the write pointer may change.
    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push_s) begin
            mem_d[wr_ptr_s] = entry_in_s;
        end else begin
            mem_d[wr_ptr_s] = mem_q[wr_ptr_s];
        end
    end

    // Storage array; deliberately not reset, contents are only meaningful when counted.
    always_ff @(posedge clk) begin
        for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign in_ready  = ~full_s;
    assign out_valid = ~empty_s;
    assign full      = full_s;
    assign empty     = empty_s;
    assign count     = count_q;
    assign out_a     = entry_out_s.a;
    assign out_b     = entry_out_s.b;
    assign out_last  = entry_out_s.last;

endmodule

// File: tb/tb_mac_operand_buffer.sv
// Self-checking bench for mac_operand_buffer (BufferWidth=2, DataWidth=8).
// The reference model is a bounded queue of operand entries.
module tb_mac_operand_buffer;
    import mac_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic       out_last;
    logic [2:0] count;
    logic       full;
    logic       empty;

    int checks   = 0;
    int failures = 0;

    operand_entry_t q[$];

    mac_operand_buffer #(.BufferWidth(2), .DataWidth(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_last  (out_last),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, advance the queue model, return 1 time unit after the edge.
    task automatic apply(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic l, input logic r, input logic f);
        bit mpush;
        bit mpop;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_last   = l;
        out_ready = r;
        flush     = f;
        mpush = v && (q.size() < DEPTH) && !f;
        mpop  = r && (q.size() > 0) && !f;
        if (f) begin
            q.delete();
        end else begin
            if (mpop) void'(q.pop_front());
            if (mpush) q.push_back(operand_entry_t'({l, a, b}));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = 8'd0; in_b = 8'd0; in_last = 1'b0;
        #12;
        if (count !== 3'd0) begin $display("FAIL reset_count act=%0d exp=0", count); failures++; end
        checks++;
        if (empty !== 1'b1) begin $display("FAIL reset_empty act=%b exp=1", empty); failures++; end
        checks++;
        if (full !== 1'b0) begin $display("FAIL reset_full act=%b exp=0", full); failures++; end
        checks++;
        if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready act=%b exp=1", in_ready); failures++; end
        checks++;
        if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid act=%b exp=0", out_valid); failures++; end
        checks++;
        rst = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 8'(2 * i + 1), 8'(2 * i + 2), (i == 3), 1'b0, 1'b0);
            if (count !== 3'(i + 1)) begin $display("FAIL fill_count act=%0d exp=%0d", count, i + 1); failures++; end
            checks++;
        end
        if (full !== 1'b1 || in_ready !== 1'b0) begin
            $display("FAIL fill_full act=%b/%b exp=1/0", full, in_ready); failures++;
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b1 || out_a !== 8'(2 * i + 1) || out_b !== 8'(2 * i + 2) || out_last !== (i == 3)) begin
                $display("FAIL drain_data idx=%0d act=%b,%0d,%0d,%b exp=1,%0d,%0d,%b",
                         i, out_valid, out_a, out_b, out_last, 2 * i + 1, 2 * i + 2, (i == 3));
                failures++;
            end
            checks++;
            apply(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        end
        if (empty !== 1'b1 || count !== 3'd0) begin
            $display("FAIL drain_empty act=%b/%0d exp=1/0", empty, count); failures++;
        end
        checks++;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
        end
        for (int j = 0; j < 3; j++) begin
            apply(1'b1, 8'd9, 8'd9, 1'b0, 1'b0, 1'b0);
            if (count !== 3'd4 || in_ready !== 1'b0 || out_a !== q[0].a || out_b !== q[0].b) begin
                $display("FAIL bp_hold cyc=%0d act=%0d,%b,%0d,%0d exp=4,0,%0d,%0d",
                         j, count, in_ready, out_a, out_b, q[0].a, q[0].b);
                failures++;
            end
            checks++;
        end
        apply(1'b1, 8'd9, 8'd9, 1'b0, 1'b1, 1'b0);
        if (count !== 3'd3 || in_ready !== 1'b1) begin
            $display("FAIL bp_pop act=%0d,%b exp=3,1", count, in_ready); failures++;
        end
        checks++;
        apply(1'b1, 8'd9, 8'd9, 1'b0, 1'b0, 1'b0);
        if (count !== 3'd4) begin $display("FAIL bp_accept act=%0d exp=4", count); failures++; end
        checks++;
        while (q.size() > 0) begin
            if (out_a !== q[0].a || out_b !== q[0].b || out_last !== q[0].last) begin
                $display("FAIL bp_drain act=%0d,%0d,%b exp=%0d,%0d,%b",
                         out_a, out_b, out_last, q[0].a, q[0].b, q[0].last);
                failures++;
            end
            checks++;
            if (q.size() == 1) begin
                if (out_a !== 8'd9 || out_b !== 8'd9 || out_last !== 1'b0) begin
                    $display("FAIL bp_tail act=%0d,%0d,%b exp=9,9,0", out_a, out_b, out_last); failures++;
                end
                checks++;
            end
            apply(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 10; k++) begin
            apply(1'b1, 8'(k), 8'(k + 1), 1'b0, 1'b1, 1'b0);
            if (count !== 3'd1 || out_valid !== 1'b1 || out_a !== 8'(k) || out_b !== 8'(k + 1)) begin
                $display("FAIL stream k=%0d act=%0d,%b,%0d,%0d exp=1,1,%0d,%0d",
                         k, count, out_valid, out_a, out_b, k, k + 1);
                failures++;
            end
            checks++;
        end
        apply(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        if (empty !== 1'b1) begin $display("FAIL stream_empty act=%b exp=1", empty); failures++; end
        checks++;
    endtask

    task automatic test_simul_at_two();
        logic [7:0] x1;
        logic [7:0] x2;
        x1 = 8'($urandom);
        x2 = 8'($urandom);
        apply(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
        apply(1'b1, x1, 8'd1, 1'b0, 1'b0, 1'b0);
        apply(1'b1, x2, 8'd2, 1'b1, 1'b1, 1'b0);
        if (count !== 3'd2 || out_a !== x1) begin
            $display("FAIL simul_hold act=%0d,%0d exp=2,%0d", count, out_a, x1); failures++;
        end
        checks++;
        apply(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        if (count !== 3'd1 || out_a !== x2 || out_b !== 8'd2 || out_last !== 1'b1) begin
            $display("FAIL simul_new act=%0d,%0d,%0d,%b exp=1,%0d,2,1", count, out_a, out_b, out_last, x2);
            failures++;
        end
        checks++;
        apply(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
        end
        apply(1'b1, 8'hAA, 8'hBB, 1'b1, 1'b1, 1'b1);
        if (count !== 3'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL flush_clear act=%0d,%b,%b exp=0,1,0", count, empty, out_valid); failures++;
        end
        checks++;
        apply(1'b1, 8'hA5, 8'hB5, 1'b0, 1'b0, 1'b0);
        if (count !== 3'd1 || out_a !== 8'hA5 || out_b !== 8'hB5) begin
            $display("FAIL flush_next act=%0d,%h,%h exp=1,a5,b5", count, out_a, out_b); failures++;
        end
        checks++;
        apply(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        apply(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
        apply(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        if (empty !== 1'b1 || count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL arst_clear act=%b,%0d,%b,%b exp=1,0,1,0", empty, count, in_ready, out_valid);
            failures++;
        end
        checks++;
        rst = 1'b0;
        q.delete();
        apply(1'b1, 8'h3C, 8'hC3, 1'b1, 1'b0, 1'b0);
        if (out_valid !== 1'b1 || out_a !== 8'h3C || out_b !== 8'hC3 || out_last !== 1'b1 || count !== 3'd1) begin
            $display("FAIL arst_first act=%b,%h,%h,%b,%0d exp=1,3c,c3,1,1", out_valid, out_a, out_b, out_last, count);
            failures++;
        end
        checks++;
        apply(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int pop_bias;
        for (int n = 0; n < 400; n++) begin
            pop_bias = ((n / 50) % 2 == 0) ? 1 : 3;
            apply(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) < pop_bias), ($urandom_range(0, 31) == 0));
            if (count !== 3'(q.size()) || full !== (q.size() == DEPTH) || empty !== (q.size() == 0) ||
                in_ready !== (q.size() < DEPTH) || out_valid !== (q.size() > 0)) begin
                $display("FAIL rand_flags n=%0d act=%0d,%b,%b,%b,%b exp_count=%0d",
                         n, count, full, empty, in_ready, out_valid, q.size());
                failures++;
            end
            checks++;
            if (q.size() > 0) begin
                if (out_a !== q[0].a || out_b !== q[0].b || out_last !== q[0].last) begin
                    $display("FAIL rand_data n=%0d act=%0d,%0d,%b exp=%0d,%0d,%b",
                             n, out_a, out_b, out_last, q[0].a, q[0].b, q[0].last);
                    failures++;
                end
                checks++;
            end
        end
    endtask

    // Run every scenario in order and report.
    initial begin
        test_reset();
        test_fill_drain();
        test_backpressure();
        test_streaming();
        test_simul_at_two();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
